mem_stage_ctrl: RTL and testbench

//  Consumer end of the EX/MEM pipeline register. Decodes the EX/MEM control bits,

---
 rtl/cpu_pipe_pkg.sv | 22 ++
 rtl/mem_wb_reg.sv | 21 ++
 rtl/mem_stage_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: MEM-stage FSM states, datapath widths and the MEM/WB bundle.
package cpu_pipe_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] rdata;
    logic [REG_W-1:0]  wn;
  } memwb_t;

  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the supplied bundle or inserts a bubble each cycle.
import cpu_pipe_pkg::*;

module mem_wb_reg (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  memwb_t i_d,
  output memwb_t o_q
);

  memwb_t r_q;

  always_ff @(posedge clk) begin
    if (rst || !i_load) r_q <= MEMWB_BUBBLE;
    else                r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage control: load/store handshake to variable-latency data memory with timeout.
// Optional macro MISALIGN_TRAP_EN: trap misaligned accesses instead of truncating the address.
import cpu_pipe_pkg::*;

module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned TO_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_regwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rd2,
  input  logic [REG_W-1:0]  ex_wn,
  output logic              stall_o,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_regwrite,
  output logic              wb_memtoreg,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_rdata,
  output logic [REG_W-1:0]  wb_wn,
`ifdef MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic              timeout_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t            r_state, w_next_state;
  logic [TO_W-1:0]   r_cnt;
  logic              r_req, r_we, r_regwrite, r_memtoreg, r_to_err;
  logic [DATA_W-1:0] r_addr, r_wdata;
  logic [REG_W-1:0]  r_wn;
  logic              w_mem_op, w_misal, w_stall, w_issue, w_done, w_abort, w_wb_load;
  memwb_t            w_wb_d, w_wb_q;

  assign w_mem_op = ex_memread | ex_memwrite;
`ifdef MISALIGN_TRAP_EN
  assign w_misal  = w_mem_op && (ex_alu_result[1:0] != 2'b00);
`else
  assign w_misal  = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_issue      = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    w_wb_load    = 1'b0;
    w_wb_d       = MEMWB_BUBBLE;
    unique case (r_state)
      IDLE: begin
        if (w_mem_op && !w_misal) begin
          w_stall      = 1'b1;
          w_issue      = 1'b1;
          w_next_state = BUSY;
        end else if (!w_mem_op) begin
          w_wb_load = 1'b1;
          w_wb_d    = '{regwrite: ex_regwrite, memtoreg: ex_memtoreg,
                        alu_result: ex_alu_result, rdata: '0, wn: ex_wn};
        end
      end
      BUSY: begin
        // Ack is checked first so a completion on the last allowed cycle is kept.
        if (dm_ack) begin
          w_done       = 1'b1;
          w_wb_load    = 1'b1;
          w_wb_d       = '{regwrite: r_regwrite, memtoreg: r_memtoreg,
                           alu_result: r_addr, rdata: (r_we ? '0 : dm_rdata), wn: r_wn};
          w_next_state = IDLE;
        end else if (r_cnt == TO_LAST) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign stall_o = w_stall & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wn       <= '0;
      r_regwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_to_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_issue) begin
        r_req      <= 1'b1;
        r_we       <= ~ex_memread;
`ifdef MISALIGN_TRAP_EN
        r_addr     <= ex_alu_result;
`else
        r_addr     <= {ex_alu_result[DATA_W-1:2], 2'b00};
`endif
        r_wdata    <= ex_rd2;
        r_wn       <= ex_wn;
        r_regwrite <= ex_regwrite;
        r_memtoreg <= ex_memtoreg;
        r_cnt      <= '0;
      end else if (w_done || w_abort) begin
        r_req <= 1'b0;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + TO_W'(1);
      end
      if (w_abort) r_to_err <= 1'b1;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= (r_state == IDLE) && w_misal;
  end
  assign misalign_o = r_misalign;
`endif

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_wb_load),
    .i_d    (w_wb_d),
    .o_q    (w_wb_q)
  );

  assign dm_req        = r_req;
  assign dm_we         = r_we;
  assign dm_addr       = r_addr;
  assign dm_wdata      = r_wdata;
  assign timeout_err   = r_to_err;
  assign wb_regwrite   = w_wb_q.regwrite;
  assign wb_memtoreg   = w_wb_q.memtoreg;
  assign wb_alu_result = w_wb_q.alu_result;
  assign wb_rdata      = w_wb_q.rdata;
  assign wb_wn         = w_wb_q.wn;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl (TIMEOUT=4); covers MISALIGN_TRAP_EN when defined.
import cpu_pipe_pkg::*;

module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite;
  logic [31:0] ex_alu_result, ex_rd2;
  logic [4:0]  ex_wn;
  logic        stall_o, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_regwrite, wb_memtoreg;
  logic [31:0] wb_alu_result, wb_rdata;
  logic [4:0]  wb_wn;
  logic        timeout_err;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  memwb_t      q_exp[$];

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(4), .TO_W(3)) dut (
    .clk(clk), .rst(rst),
    .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_alu_result(ex_alu_result), .ex_rd2(ex_rd2), .ex_wn(ex_wn),
    .stall_o(stall_o), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_alu_result(wb_alu_result), .wb_rdata(wb_rdata), .wb_wn(wb_wn),
`ifdef MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .timeout_err(timeout_err)
  );

  function automatic memwb_t mk(input logic rw, input logic mtr, input logic [31:0] alu,
                                input logic [31:0] rd, input logic [4:0] wn);
    memwb_t m;
    m.regwrite = rw; m.memtoreg = mtr; m.alu_result = alu; m.rdata = rd; m.wn = wn;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_ex(input logic rw, input logic mtr, input logic mr, input logic mw,
                        input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wn);
    ex_regwrite = rw; ex_memtoreg = mtr; ex_memread = mr; ex_memwrite = mw;
    ex_alu_result = alu; ex_rd2 = rd2; ex_wn = wn;
  endtask

  // Inputs are already driven; expectation queued now, popped once the edge has produced it.
  task automatic run_cycle(input string nm, input logic exp_stall, input memwb_t exp_wb);
    memwb_t act, exp;
    q_exp.push_back(exp_wb);
    @(negedge clk);
    chk({nm, "_stall"}, 72'(stall_o), 72'(exp_stall));
    @(posedge clk);
    #1;
    act = mk(wb_regwrite, wb_memtoreg, wb_alu_result, wb_rdata, wb_wn);
    if (q_exp.size() == 0) begin
      chk({nm, "_sb_empty"}, 72'(1), 72'(0));
    end else begin
      exp = q_exp.pop_front();
      chk({nm, "_wb"}, 72'(act), 72'(exp));
    end
  endtask

  typedef struct {
    logic        rw, mtr;
    logic [31:0] alu;
    logic [4:0]  wn;
    memwb_t      exp;
  } vec_t;

  vec_t tv[4];

  initial begin
    tv[0] = '{rw: 1'b1, mtr: 1'b0, alu: 32'h10,       wn: 5'd5,  exp: mk(1'b1, 1'b0, 32'h10, 32'h0, 5'd5)};
    tv[1] = '{rw: 1'b0, mtr: 1'b0, alu: 32'hFFFFFFFF, wn: 5'd31, exp: mk(1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 5'd31)};
    tv[2] = '{rw: 1'b1, mtr: 1'b1, alu: 32'h0,        wn: 5'd0,  exp: mk(1'b1, 1'b1, 32'h0, 32'h0, 5'd0)};
    tv[3] = '{rw: 1'b1, mtr: 1'b0, alu: 32'h80000001, wn: 5'd17, exp: mk(1'b1, 1'b0, 32'h80000001, 32'h0, 5'd17)};

    rst = 1'b1; dm_ack = 1'b0; dm_rdata = '0;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb", 72'(mk(wb_regwrite, wb_memtoreg, wb_alu_result, wb_rdata, wb_wn)), 72'(0));
    chk("rst_dm_req", 72'(dm_req), 72'(0));
    chk("rst_timeout", 72'(timeout_err), 72'(0));
    chk("rst_stall", 72'(stall_o), 72'(0));
    rst = 1'b0;

    // ALU pass-through table
    for (int i = 0; i < 4; i++) begin
      set_ex(tv[i].rw, tv[i].mtr, 1'b0, 1'b0, tv[i].alu, 32'h5A5A5A5A, tv[i].wn);
      run_cycle($sformatf("alu%0d", i), 1'b0, tv[i].exp);
    end

    // Load: ack arrives on the 4th BUSY cycle (counter at TIMEOUT-1, ack wins)
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd7);
    run_cycle("ld_idle", 1'b1, MEMWB_BUBBLE);
    chk("ld_req", 72'({dm_req, dm_we, dm_addr}), 72'({1'b1, 1'b0, 32'h40}));
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h999, 32'h777, 5'd9);
    for (int i = 0; i < 3; i++) begin
      run_cycle($sformatf("ld_busy%0d", i), 1'b1, MEMWB_BUBBLE);
      chk($sformatf("ld_hold%0d", i), 72'({dm_req, dm_we, dm_addr}), 72'({1'b1, 1'b0, 32'h40}));
    end
    dm_ack = 1'b1; dm_rdata = 32'hDEADBEEF;
    run_cycle("ld_ack", 1'b0, mk(1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 5'd7));
    dm_ack = 1'b0; dm_rdata = '0;
    chk("ld_req_drop", 72'(dm_req), 72'(0));
    chk("ld_no_timeout", 72'(timeout_err), 72'(0));

    // Store with one wait cycle; rdata on ack must not reach wb_rdata
    set_ex(1'b0, 1'b0, 1'b0, 1'b1, 32'h44, 32'h1234, 5'd3);
    run_cycle("st_idle", 1'b1, MEMWB_BUBBLE);
    chk("st_req", 72'({dm_req, dm_we, dm_addr, dm_wdata}), 72'({1'b1, 1'b1, 32'h44, 32'h1234}));
    run_cycle("st_busy", 1'b1, MEMWB_BUBBLE);
    chk("st_hold", 72'({dm_req, dm_we, dm_wdata}), 72'({1'b1, 1'b1, 32'h1234}));
    dm_ack = 1'b1; dm_rdata = 32'hAAAA5555;
    run_cycle("st_ack", 1'b0, mk(1'b0, 1'b0, 32'h44, 32'h0, 5'd3));
    dm_ack = 1'b0; dm_rdata = '0;
    chk("st_req_drop", 72'(dm_req), 72'(0));

    // Timeout: 4 BUSY cycles without ack
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 5'd2);
    run_cycle("to_idle", 1'b1, MEMWB_BUBBLE);
    for (int i = 0; i < 3; i++) begin
      run_cycle($sformatf("to_busy%0d", i), 1'b1, MEMWB_BUBBLE);
      chk($sformatf("to_req%0d", i), 72'({dm_req, timeout_err}), 72'({1'b1, 1'b0}));
    end
    run_cycle("to_abort", 1'b0, MEMWB_BUBBLE);
    chk("to_flags", 72'({dm_req, timeout_err}), 72'({1'b0, 1'b1}));
    // Stray ack in IDLE is ignored; error stays sticky
    dm_ack = 1'b1; dm_rdata = 32'h11111111;
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 5'd11);
    run_cycle("to_after", 1'b0, mk(1'b1, 1'b0, 32'h77, 32'h0, 5'd11));
    dm_ack = 1'b0; dm_rdata = '0;
    chk("to_sticky", 72'({dm_req, timeout_err}), 72'({1'b0, 1'b1}));

    // Read+write together acts as a load; reset mid-BUSY drops the request
    set_ex(1'b1, 1'b1, 1'b1, 1'b1, 32'h60, 32'h99, 5'd4);
    run_cycle("rw_idle", 1'b1, MEMWB_BUBBLE);
    chk("rw_is_load", 72'({dm_req, dm_we}), 72'({1'b1, 1'b0}));
    run_cycle("rw_busy0", 1'b1, MEMWB_BUBBLE);
    run_cycle("rw_busy1", 1'b1, MEMWB_BUBBLE);
    rst = 1'b1; dm_ack = 1'b1; dm_rdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    rst = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    chk("mrst_wb", 72'(mk(wb_regwrite, wb_memtoreg, wb_alu_result, wb_rdata, wb_wn)), 72'(0));
    chk("mrst_flags", 72'({dm_req, timeout_err}), 72'(0));
    set_ex(1'b1, 1'b0, 1'b0, 1'b0, 32'h123, 32'h0, 5'd6);
    run_cycle("mrst_idle", 1'b0, mk(1'b1, 1'b0, 32'h123, 32'h0, 5'd6));

    // Misaligned load at 0x42
    set_ex(1'b1, 1'b1, 1'b1, 1'b0, 32'h42, 32'h0, 5'd8);
`ifdef MISALIGN_TRAP_EN
    run_cycle("mis_idle", 1'b0, MEMWB_BUBBLE);
    chk("mis_flags", 72'({dm_req, misalign_o}), 72'({1'b0, 1'b1}));
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    run_cycle("mis_after", 1'b0, mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0));
    chk("mis_pulse", 72'(misalign_o), 72'(0));
`else
    run_cycle("mis_idle", 1'b1, MEMWB_BUBBLE);
    chk("mis_addr", 72'({dm_req, dm_addr}), 72'({1'b1, 32'h40}));
    dm_ack = 1'b1; dm_rdata = 32'h0BADF00D;
    run_cycle("mis_ack", 1'b0, mk(1'b1, 1'b1, 32'h40, 32'h0BADF00D, 5'd8));
    dm_ack = 1'b0; dm_rdata = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
